// File: rtl/serial_adder.sv
// serial_adder: WIDTH-bit add/sub, STEP bits per clock (in: clk rst start a b cin sub; out: busy done sum cout ovf)
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int STEP = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int N = WIDTH / STEP;
  localparam int CW = N > 1 ? $clog2(N) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t r_state, w_next;
  logic [WIDTH-1:0] r_a, r_b, r_res, w_res;
  logic [CW-1:0] r_cnt;
  logic [STEP:0] w_slice;
  logic r_c, w_last, w_load, w_cmsb;
  if (STEP < 1 || STEP > WIDTH || WIDTH % STEP != 0) begin : g_bad
    $error("serial_adder: STEP must divide WIDTH and lie in 1..WIDTH");
  end
  assign w_slice = {1'b0, r_a[STEP-1:0]} + {1'b0, r_b[STEP-1:0]} + {{STEP{1'b0}}, r_c};
  assign w_res = WIDTH'({w_slice[STEP-1:0], r_res} >> STEP);
  assign w_cmsb = w_slice[STEP-1] ^ r_a[STEP-1] ^ r_b[STEP-1];
  assign w_last = r_cnt == CW'(N - 1);
  assign w_load = start && r_state != RUN;
  assign busy = r_state == RUN;
  assign done = r_state == DONE;
  always_comb begin
    w_next = r_state == RUN ? (w_last ? DONE : RUN) : (start ? RUN : IDLE);
  end
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a <= '0;
      r_b <= '0;
      r_c <= 1'b0;
      r_cnt <= '0;
      r_res <= '0;
      sum <= '0;
      cout <= 1'b0;
      ovf <= 1'b0;
    end else if (w_load) begin
      r_a <= a;
      r_b <= b ^ {WIDTH{sub}};
      r_c <= cin ^ sub;
      r_cnt <= '0;
    end else if (busy) begin
      r_a <= r_a >> STEP;
      r_b <= r_b >> STEP;
      r_c <= w_slice[STEP];
      r_cnt <= r_cnt + CW'(1);
      r_res <= w_res;
      if (w_last) begin
        sum <= w_res;
        cout <= w_slice[STEP];
        ovf <= w_cmsb ^ w_slice[STEP];
      end
    end
  end
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: random and directed checks of three serial_adder configurations against an arithmetic model
module tb_serial_adder;
  localparam int WS[3] = '{8, 8, 1};
  localparam int NS[3] = '{8, 2, 1};
  logic clk = 0, rst = 1, cin = 0, sub = 0, go = 0;
  logic [7:0] a = 0, b = 0;
  logic [2:0] st = 0, bsy, dn, co, ov;
  logic [7:0] s0, s1;
  logic s2;
  logic [7:0] sum_of[3];
  int vectors = 0, miscompares = 0;
  int cnt[3];
  logic [2:0] m_done, m_co, m_ov;
  logic [7:0] m_sum[3];
  logic [9:0] pend[3];
  always #5 clk = ~clk;
  serial_adder #(.WIDTH(8), .STEP(1)) u0 (.clk(clk), .rst(rst), .start(st[0]), .a(a), .b(b), .cin(cin), .sub(sub),
    .busy(bsy[0]), .done(dn[0]), .sum(s0), .cout(co[0]), .ovf(ov[0]));
  serial_adder #(.WIDTH(8), .STEP(4)) u1 (.clk(clk), .rst(rst), .start(st[1]), .a(a), .b(b), .cin(cin), .sub(sub),
    .busy(bsy[1]), .done(dn[1]), .sum(s1), .cout(co[1]), .ovf(ov[1]));
  serial_adder #(.WIDTH(1), .STEP(1)) u2 (.clk(clk), .rst(rst), .start(st[2]), .a(a[0]), .b(b[0]), .cin(cin), .sub(sub),
    .busy(bsy[2]), .done(dn[2]), .sum(s2), .cout(co[2]), .ovf(ov[2]));
  assign sum_of[0] = s0;
  assign sum_of[1] = s1;
  assign sum_of[2] = {7'b0, s2};
  function automatic logic [9:0] calc(int w, logic [7:0] av, logic [7:0] bv, logic ci, logic sb);
    longint m = longint'(1) << w;
    longint ua = longint'(av) % m;
    longint ub = longint'(bv) % m;
    longint c = longint'(ci);
    longint sa = ua >= m / 2 ? ua - m : ua;
    longint sbv = ub >= m / 2 ? ub - m : ub;
    longint r = sb ? sa - sbv - c : sa + sbv + c;
    longint u = sb ? ua - ub - c : ua + ub + c;
    logic o = r < -(m / 2) || r >= m / 2;
    logic cy = sb ? ua >= ub + c : u >= m;
    longint s = ((u % m) + m) % m;
    return {8'(s), cy, o};
  endfunction
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        cnt[k] <= 0;
        m_done[k] <= 1'b0;
        m_sum[k] <= 8'h0;
        m_co[k] <= 1'b0;
        m_ov[k] <= 1'b0;
      end else if (cnt[k] > 0) begin
        cnt[k] <= cnt[k] - 1;
        if (cnt[k] == 1) begin
          m_done[k] <= 1'b1;
          m_sum[k] <= pend[k][9:2];
          m_co[k] <= pend[k][1];
          m_ov[k] <= pend[k][0];
        end
      end else begin
        m_done[k] <= 1'b0;
        if (st[k]) begin
          cnt[k] <= NS[k];
          pend[k] <= calc(WS[k], a, b, cin, sub);
        end
      end
    end
  end
  always @(negedge clk) begin
    if (go) begin
      for (int k = 0; k < 3; k++) begin
        vectors++;
        if (bsy[k] !== (cnt[k] > 0) || dn[k] !== m_done[k] || sum_of[k] !== m_sum[k] || co[k] !== m_co[k] || ov[k] !== m_ov[k]) begin
          miscompares++;
          $display("FAIL model[%0d] t=%0t: busy/done/sum/cout/ovf got %b/%b/%h/%b/%b want %b/%b/%h/%b/%b", k, $time,
            bsy[k], dn[k], sum_of[k], co[k], ov[k], cnt[k] > 0, m_done[k], m_sum[k], m_co[k], m_ov[k]);
        end
      end
    end
  end
  task automatic step();
    @(posedge clk);
    #2;
  endtask
  task automatic chk(string name, logic [7:0] got, logic [7:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", name, got, exp);
    end
  endtask
  task automatic launch(int k, logic [7:0] av, logic [7:0] bv, logic ci, logic sb);
    a = av;
    b = bv;
    cin = ci;
    sub = sb;
    st[k] = 1'b1;
    step();
    st[k] = 1'b0;
  endtask
  task automatic wait_done(int k, int expect_edges);
    int e = 1;
    while (!dn[k] && e < 20) begin
      step();
      e++;
    end
    vectors++;
    if (!dn[k] || e != expect_edges) begin
      miscompares++;
      $display("FAIL latency[%0d]: done=%b after %0d edges want %0d", k, dn[k], e, expect_edges);
    end
  endtask
  task automatic op(int k, logic [7:0] av, logic [7:0] bv, logic ci, logic sb, logic [7:0] es, logic ec, logic eo);
    launch(k, av, bv, ci, sb);
    wait_done(k, NS[k] + 1);
    chk($sformatf("sum[%0d] %h,%h", k, av, bv), sum_of[k], es);
    chk($sformatf("cout[%0d] %h,%h", k, av, bv), {7'b0, co[k]}, {7'b0, ec});
    chk($sformatf("ovf[%0d] %h,%h", k, av, bv), {7'b0, ov[k]}, {7'b0, eo});
  endtask
  initial begin
    repeat (3) step();
    go = 1;
    chk("reset sum", s0, 8'h00);
    chk("reset flags", {3'b0, bsy[0], dn[0], co[0], ov[0], s2}, 8'h00);
    rst = 0;
    op(0, 8'h5A, 8'h3C, 0, 0, 8'h96, 0, 1);
    op(0, 8'hFF, 8'h01, 0, 0, 8'h00, 1, 0);
    op(0, 8'h7F, 8'h00, 1, 0, 8'h80, 0, 1);
    op(0, 8'h10, 8'h20, 0, 1, 8'hF0, 0, 0);
    op(0, 8'h10, 8'h01, 1, 1, 8'h0E, 1, 0);
    op(1, 8'hAB, 8'hCD, 0, 0, 8'h78, 1, 1);
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v = 3'(i);
      launch(2, {7'b0, v[2]}, {7'b0, v[1]}, v[0], 0);
      wait_done(2, 2);
      chk($sformatf("fa %b", v), {6'b0, co[2], s2}, 8'(v[2] + v[1] + v[0]));
    end
    launch(0, 8'h5A, 8'h3C, 0, 0);
    repeat (2) step();
    a = 8'h00;
    b = 8'h00;
    st[0] = 1'b1;
    step();
    st[0] = 1'b0;
    wait_done(0, NS[0] - 2);
    chk("ignored start", s0, 8'h96);
    step();
    launch(0, 8'h11, 8'h22, 0, 0);
    repeat (3) step();
    rst = 1;
    step();
    rst = 0;
    chk("abort flags", {4'b0, bsy[0], dn[0], co[0], ov[0]}, 8'h00);
    chk("abort sum", s0, 8'h00);
    for (int i = 0; i < 12; i++) begin
      step();
      chk("abort no done", {7'b0, dn[0]}, 8'h00);
    end
    a = 8'h5A;
    b = 8'h3C;
    cin = 0;
    sub = 0;
    st[0] = 1'b1;
    step();
    wait_done(0, NS[0] + 1);
    chk("b2b first", s0, 8'h96);
    a = 8'hFF;
    b = 8'h01;
    step();
    st[0] = 1'b0;
    wait_done(0, NS[0] + 1);
    chk("b2b second", s0, 8'h00);
    chk("b2b cout", {7'b0, co[0]}, 8'h01);
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 300; i++) begin
        a = 8'($urandom);
        b = 8'($urandom);
        cin = 1'($urandom);
        sub = 1'($urandom);
        st[k] = ($urandom % 3) == 0;
        rst = ($urandom % 60) == 0;
        step();
      end
      st = 0;
      rst = 0;
      repeat (12) step();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/serial_adder.md
# serial_adder

Parametrised multi-cycle adder/subtractor, the sequential successor to the single-bit `full_adder`. It processes a WIDTH-bit operand pair STEP bits per clock through an internal STEP-bit ripple slice and a registered carry. A start/done handshake frames each operation. Results are signed/unsigned sum, carry-out and signed overflow. It serves datapaths where a small slice reused over several cycles is preferred over a full-width combinational adder.

## Interface
- `WIDTH`, default 8: operand/result width in bits; at least 1.
- `STEP`, default 1: bits processed per cycle; 1 ≤ STEP ≤ WIDTH and WIDTH % STEP == 0. Elaboration fails otherwise.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request; sampled only in IDLE or DONE.
- `a`  in  WIDTH  operand A; sampled with an accepted start.
- `b`  in  WIDTH  operand B; sampled with an accepted start.
- `cin`  in  1  carry-in (add) / borrow-in (sub); sampled with an accepted start.
- `sub`  in  1  0 = a + b + cin; 1 = a − b − cin; sampled with an accepted start.
- `busy`  out  1  high while in RUN.
- `done`  out  1  one-cycle pulse; sum/cout/ovf valid from this cycle on.
- `sum`  out  WIDTH  result, registered.
- `cout`  out  1  raw carry out of the MSB; for sub, 1 = no borrow.
- `ovf`  out  1  signed overflow = carry into MSB XOR carry out of MSB.

## Operation
- Let N = WIDTH/STEP. The FSM states are IDLE, RUN and DONE.
- IDLE → RUN on `start`=1.
  - Load operand shift registers with `a` and `b ^ {WIDTH{sub}}`.
  - Set carry register = `cin ^ sub`.
  - Clear the slice counter.
- RUN, each cycle:
  - Add the low STEP bits of both shift registers plus the carry register.
  - Shift the STEP result bits into the MSB end of the result shift register.
  - Shift both operand registers right by STEP.
  - Update the carry register.
  - Increment the counter.
  - On the last slice (counter = N−1), record carry into the MSB and carry out of the MSB, then go to DONE.
- RUN → DONE on the edge that completes slice N−1.
  - At that edge, `sum` ← result register, `cout` ← final carry, `ovf` ← (carry into MSB) XOR (carry out).
- DONE lasts exactly one cycle, with `done`=1.
  - If `start`=1 in DONE, the next operation is accepted (→ RUN, operands loaded as in IDLE).
  - Otherwise → IDLE.
- `start` during RUN is ignored; operand changes during RUN have no effect.
- `sum`/`cout`/`ovf` change only at the RUN→DONE edge or on reset. Partial results are never visible.
- Arithmetic is modulo 2^WIDTH. WIDTH=1 reproduces full-adder truth-table behaviour (`sum`=s, `cout`=c).

## Timing
- Reset: `rst`=1 at an edge sets state=IDLE, `busy`=0, `done`=0, `sum`=0, `cout`=0, `ovf`=0 and clears internal registers.
  - Reset takes priority over `start` and over any in-flight RUN. An aborted operation produces no `done`.
- Start accepted at edge t:
  - `busy`=1 from t through t+N.
  - `busy`=0 and `done`=1 for the cycle after edge t+N.
  - Latency is N+1 edges from accept to the `done` cycle.
- Back-to-back: with `start` held high in DONE, the next operation is accepted at edge t+N+1. Throughput is one result per N+1 cycles.
- `busy` and `done` are never high simultaneously.

## Test plan
- WIDTH=8, STEP=1, add 0x5A + 0x3C, cin=0 → `sum`=0x96, `cout`=0, `ovf`=1; `busy` high for exactly 8 cycles; `done` pulses once, 9 edges after accept.
- WIDTH=8, STEP=1 adds:
  - 0xFF + 0x01, cin=0 → 0x00, `cout`=1, `ovf`=0.
  - 0x7F + 0x00, cin=1 → 0x80, `cout`=0, `ovf`=1.
- WIDTH=8, STEP=1 subtracts (sub=1):
  - 0x10 − 0x20, cin=0 → 0xF0, `cout`=0, `ovf`=0.
  - 0x10 − 0x01, cin=1 → 0x0E, `cout`=1, `ovf`=0.
- WIDTH=8, STEP=4, add 0xAB + 0xCD → `sum`=0x78, `cout`=1, `ovf`=1; `busy` lasts 2 cycles, `done` 3 edges after accept.
- Control/abort sequence:
  - Pulse `start` again mid-RUN → ignored; result unchanged.
  - Assert `rst` at RUN slice 3 → next cycle `busy`=0, all outputs 0, no `done`.
  - Hold `start` through DONE → second operation runs back-to-back with correct result.
- WIDTH=1, STEP=1: all 8 {a,b,cin} combinations with sub=0 → {`cout`,`sum`} = a+b+cin; `done` 2 edges after each accept.
